// File: rtl/alu_pkg.sv
// Shared encodings for the sequenced ALU/register-file datapath: opcodes,
// FSM states and flag bit positions.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_ADC = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_SHL = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;

   // Bitwise ops leave carry and overflow untouched.
   function automatic logic is_logic_op(input logic [2:0] op);
      return op inside {OP_AND, OP_OR, OP_XOR};
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub with carry-in, bitwise logic and shift-left.
// c is carry-out (no-borrow for subtracts); v is signed overflow.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             v
);

   logic [WIDTH-1:0] b_eff;
   logic             carry_in;
   logic [WIDTH:0]   sum;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      b_eff    = b;
      carry_in = 1'b0;
      case (op)
         OP_SUB:  begin b_eff = ~b; carry_in = 1'b1; end
         OP_ADC:  carry_in = cin;
         OP_SBC:  begin b_eff = ~b; carry_in = cin; end
         default: ;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};

   always_comb begin
      result = sum[WIDTH-1:0];
      c      = sum[WIDTH];
      v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      case (op)
         OP_AND:  begin result = a & b; c = 1'b0; v = 1'b0; end
         OP_OR:   begin result = a | b; c = 1'b0; v = 1'b0; end
         OP_XOR:  begin result = a ^ b; c = 1'b0; v = 1'b0; end
         OP_SHL:  begin result = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; v = 1'b0; end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_regfile_seq.sv
// NREG x WIDTH register file feeding a four-state sequenced ALU through a
// valid/ready command port; results are written back and flags held for chaining.
module alu_regfile_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREG  = 4
) (
   input  logic                    MainClock,
   input  logic                    MainReset,
   input  logic                    ld_en,
   input  logic [$clog2(NREG)-1:0] ld_addr,
   input  logic [WIDTH-1:0]        ld_data,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [2:0]              cmd_op,
   input  logic [$clog2(NREG)-1:0] cmd_dst,
   input  logic [$clog2(NREG)-1:0] cmd_srca,
   input  logic [$clog2(NREG)-1:0] cmd_srcb,
   input  logic                    out_en,
   output logic                    res_valid,
   output logic [WIDTH-1:0]        res_bus,
   output logic                    flag_c,
   output logic                    flag_z,
   output logic                    flag_v,
   output logic                    flag_n
);

   localparam int AW = $clog2(NREG);

   state_t           state;
   logic [2:0]       op_q;
   logic [AW-1:0]    dst_q;
   logic [AW-1:0]    srca_q;
   logic [AW-1:0]    srcb_q;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic [3:0]       flags_next;
   logic [3:0]       flags_d;
   logic [WIDTH-1:0] regs [NREG];

   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .op     (op_q),
      .a      (ra),
      .b      (rb),
      .cin    (flags[FLAG_C]),
      .result (alu_res),
      .c      (alu_c),
      .v      (alu_v)
   );

   always_comb begin
      flags_d = flags;
      if (!is_logic_op(op_q)) begin
         flags_d[FLAG_C] = alu_c;
         flags_d[FLAG_V] = alu_v;
      end
      flags_d[FLAG_Z] = (alu_res == '0);
      flags_d[FLAG_N] = alu_res[WIDTH-1];
   end

   // NOTE: sequential state uses <= only, so READ samples the file as it stood before the edge.
   always_ff @(posedge MainClock) begin
      if (MainReset) begin
         state      <= S_IDLE;
         cmd_ready  <= 1'b1;
         res_valid  <= 1'b0;
         op_q       <= OP_ADD;
         dst_q      <= '0;
         srca_q     <= '0;
         srcb_q     <= '0;
         ra         <= '0;
         rb         <= '0;
         result     <= '0;
         flags      <= '0;
         flags_next <= '0;
         // NOTE: the file is cleared on reset, which keeps it in flops rather than a RAM.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         res_valid <= 1'b0;
         // Load is scheduled first so a same-address writeback below overrides it.
         if (ld_en) regs[ld_addr] <= ld_data;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  dst_q     <= cmd_dst;
                  srca_q    <= cmd_srca;
                  srcb_q    <= cmd_srcb;
                  cmd_ready <= 1'b0;
                  state     <= S_READ;
               end
            end
            S_READ: begin
               ra    <= regs[srca_q];
               rb    <= regs[srcb_q];
               state <= S_EXEC;
            end
            S_EXEC: begin
               result     <= alu_res;
               flags_next <= flags_d;
               state      <= S_WB;
            end
            S_WB: begin
               regs[dst_q] <= result;
               flags       <= flags_next;
               res_valid   <= 1'b1;
               cmd_ready   <= 1'b1;
               state       <= S_IDLE;
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   assign res_bus = out_en ? result : '0;
   assign flag_c  = flags[FLAG_C];
   assign flag_z  = flags[FLAG_Z];
   assign flag_v  = flags[FLAG_V];
   assign flag_n  = flags[FLAG_N];

endmodule
